// File: rtl/tx_link_seq_pkg.sv
// Shared definitions for the transmit link sequencer: link state encoding and
// the 8b/10b control characters emitted during CGS and ILAS.
package tx_link_seq_pkg;

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } link_state_e;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  localparam int CFG_OCTETS = 14;

endpackage

// File: rtl/tx_link_seq.sv
// Transmit link sequencer: CGS comma stream, 4-multiframe ILAS and user data
// pass-through, all paced by a free-running LMFC octet counter.
module tx_link_seq
  import tx_link_seq_pkg::*;
#(
  parameter int F             = 2,
  parameter int K             = 32,
  parameter int SYNC_LOSS_CYC = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_sync_n,
  input  logic [8*CFG_OCTETS-1:0]   i_cfg,
  input  logic [7:0]                i_data,
  input  logic                      i_vld,
  output logic                      o_ready,
  output logic [7:0]                o_data,
  output logic                      o_vld,
  output logic                      o_k,
  output logic [1:0]                o_state
);

  localparam int FK = F * K;
  localparam int LW = $clog2(FK);
  localparam int IW = ($clog2(4 * FK) > 8) ? $clog2(4 * FK) : 8;
  localparam int SW = $clog2(SYNC_LOSS_CYC + 1);

  localparam logic [LW-1:0] LMFC_LAST    = LW'(FK - 1);
  localparam logic [LW-1:0] CFG_LAST_OCT = LW'(CFG_OCTETS + 1);
  localparam logic [IW-1:0] MF1_FIRST    = IW'(FK);
  localparam logic [IW-1:0] MF2_FIRST    = IW'(2 * FK);
  localparam logic [IW-1:0] ILAS_LAST    = IW'(4 * FK - 1);
  localparam logic [SW-1:0] LOSS_MAX     = SW'(SYNC_LOSS_CYC);

  link_state_e     state_q, state_d;
  logic [LW-1:0]   lmfc_cnt;
  logic [IW-1:0]   ilas_idx, ilas_idx_d;
  logic [SW-1:0]   loss_cnt, loss_d;
  logic            sync_q;
  logic [7:0]      data_d;
  logic            k_d, vld_d;
  logic            lmfc_wrap, second_mf;
  logic [3:0]      cfg_sel;
  logic [15:0][7:0] cfg_ext;

  assign lmfc_wrap = (lmfc_cnt == LMFC_LAST);
  assign second_mf = (ilas_idx >= MF1_FIRST) && (ilas_idx < MF2_FIRST);
  assign cfg_ext   = {16'h0000, i_cfg};
  assign cfg_sel   = lmfc_cnt[3:0] - 4'd2;

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    ilas_idx_d = '0;
    loss_d     = '0;
    data_d     = 8'h00;
    k_d        = 1'b0;
    vld_d      = 1'b0;

    unique case (state_q)
      ST_CGS: begin
        data_d = K28_5;
        k_d    = 1'b1;
        vld_d  = 1'b1;
        if (lmfc_wrap && i_sync_n && sync_q) state_d = ST_ILAS;
      end
      ST_ILAS: begin
        vld_d = 1'b1;
        // ILAS starts on an LMFC boundary, so lmfc_cnt is the octet position
        // inside the current ILAS multiframe.
        if (lmfc_cnt == '0) begin
          data_d = K28_0;
          k_d    = 1'b1;
        end else if (lmfc_wrap) begin
          data_d = K28_3;
          k_d    = 1'b1;
        end else if (second_mf && lmfc_cnt == LW'(1)) begin
          data_d = K28_4;
          k_d    = 1'b1;
        end else if (second_mf && lmfc_cnt <= CFG_LAST_OCT) begin
          data_d = cfg_ext[cfg_sel];
        end else begin
          data_d = ilas_idx[7:0];
        end
        if (ilas_idx == ILAS_LAST) state_d = ST_DATA;
        else                       ilas_idx_d = ilas_idx + 1'b1;
      end
      ST_DATA: begin
        data_d = i_data;
        vld_d  = i_vld;
      end
      default: state_d = ST_CGS;
    endcase

    // Short SYNC~ pulses are error reports; only a sustained low restarts CGS.
    if (state_q != ST_CGS && !i_sync_n) begin
      loss_d = (loss_cnt == LOSS_MAX) ? LOSS_MAX : loss_cnt + 1'b1;
      if (loss_d == LOSS_MAX) begin
        state_d    = ST_CGS;
        ilas_idx_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CGS;
      lmfc_cnt <= '0;
      ilas_idx <= '0;
      loss_cnt <= '0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lmfc_cnt <= lmfc_wrap ? '0 : lmfc_cnt + 1'b1;
      ilas_idx <= ilas_idx_d;
      loss_cnt <= loss_d;
      sync_q   <= i_sync_n;
    end
  end

  // o_state tags the octet currently on o_data; o_ready tracks the state in
  // which i_data is being sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data  <= 8'h00;
      o_k     <= 1'b0;
      o_vld   <= 1'b0;
      o_ready <= 1'b0;
      o_state <= 2'd0;
    end else begin
      o_data  <= data_d;
      o_k     <= k_d;
      o_vld   <= vld_d;
      o_ready <= (state_d == ST_DATA);
      o_state <= state_q;
    end
  end

endmodule

// File: tb/tb_tx_link_seq.sv
// Self-checking bench for tx_link_seq: a cycle-level reference model derived
// from the link sequencing rules, plus stimulus tables for ILAS and DATA.
module tb_tx_link_seq;

  localparam int F  = 2;
  localparam int K  = 32;
  localparam int N  = 5;
  localparam int FK = F * K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_sync_n;
  logic [111:0] i_cfg;
  logic [7:0]   i_data;
  logic         i_vld;
  logic         o_ready;
  logic [7:0]   o_data;
  logic         o_vld;
  logic         o_k;
  logic [1:0]   o_state;

  tx_link_seq #(.F(F), .K(K), .SYNC_LOSS_CYC(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sync_n (i_sync_n),
    .i_cfg    (i_cfg),
    .i_data   (i_data),
    .i_vld    (i_vld),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_vld    (o_vld),
    .o_k      (o_k),
    .o_state  (o_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0/1/2 = CGS/ILAS/DATA, cycles counted since reset.
  int m_mode, m_cyc, m_ilas, m_low;
  bit m_prev;

  // Capture of octets tagged as ILAS on the output.
  bit         cap_en;
  int         cap_n;
  logic [8:0] cap [256];

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; m_ilas = 0; m_low = 0; m_prev = 1'b0;
  endtask

  function automatic logic [8:0] ilas_octet(input int idx, input logic [111:0] cfg);
    int mf, o;
    logic [111:0] sh;
    mf = idx / FK;
    o  = idx % FK;
    if (o == 0)                     return {1'b1, 8'h1C};
    if (o == FK - 1)                return {1'b1, 8'h7C};
    if (mf == 1 && o == 1)          return {1'b1, 8'h9C};
    if (mf == 1 && o >= 2 && o <= 15) begin
      sh = cfg >> (8 * (o - 2));
      return {1'b0, sh[7:0]};
    end
    return {1'b0, 8'(idx % 256)};
  endfunction

  // One clock: predict from current inputs, advance, compare registered outputs.
  task automatic step();
    int lm, nxt;
    logic [8:0] oct;
    logic [7:0] e_d;
    logic e_k, e_v, e_r;
    lm  = m_cyc % FK;
    nxt = m_mode;
    e_d = 8'h00; e_k = 1'b0; e_v = 1'b0;
    case (m_mode)
      0: begin
        e_d = 8'hBC; e_k = 1'b1; e_v = 1'b1;
        if (lm == FK - 1 && i_sync_n && m_prev) nxt = 1;
      end
      1: begin
        oct = ilas_octet(m_ilas, i_cfg);
        e_k = oct[8]; e_d = oct[7:0]; e_v = 1'b1;
        if (m_ilas == 4 * FK - 1) nxt = 2;
      end
      default: begin
        e_d = i_data; e_v = i_vld;
      end
    endcase
    if (m_mode != 0) begin
      m_low = i_sync_n ? 0 : m_low + 1;
      if (m_low >= N) nxt = 0;
    end
    if (nxt == 0) m_low = 0;
    m_ilas = (m_mode == 1 && nxt == 1) ? m_ilas + 1 : 0;
    e_r = (nxt == 2);
    @(posedge clk); #1;
    check("o_state", 32'(o_state), 32'(m_mode));
    check("o_vld",   32'(o_vld),   32'(e_v));
    check("o_k",     32'(o_k),     32'(e_k));
    check("o_ready", 32'(o_ready), 32'(e_r));
    if (e_v) check("o_data", 32'(o_data), 32'(e_d));
    if (cap_en && o_state == 2'd1 && cap_n < 256) begin
      cap[cap_n] = {o_k, o_data};
      cap_n++;
    end
    m_mode = nxt;
    m_cyc++;
    m_prev = i_sync_n;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(o_data),  32'h0);
    check({tag, "_k"},     32'(o_k),     32'h0);
    check({tag, "_vld"},   32'(o_vld),   32'h0);
    check({tag, "_ready"}, 32'(o_ready), 32'h0);
    check({tag, "_state"}, 32'(o_state), 32'h0);
  endtask

  typedef struct {
    int         pos;
    logic [7:0] d;
    logic       k;
  } ilas_vec_t;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [7:0] ed;
    logic       ev;
  } data_vec_t;

  ilas_vec_t ilas_tbl [9];
  data_vec_t data_tbl [$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Config octet n = 0xA0 + n.
    for (int n = 0; n < 14; n++) i_cfg[8*n +: 8] = 8'(8'hA0 + n);

    ilas_tbl[0] = '{pos: 0,   d: 8'h1C, k: 1'b1};
    ilas_tbl[1] = '{pos: 1,   d: 8'h01, k: 1'b0};
    ilas_tbl[2] = '{pos: 63,  d: 8'h7C, k: 1'b1};
    ilas_tbl[3] = '{pos: 64,  d: 8'h1C, k: 1'b1};
    ilas_tbl[4] = '{pos: 65,  d: 8'h9C, k: 1'b1};
    ilas_tbl[5] = '{pos: 66,  d: 8'hA0, k: 1'b0};
    ilas_tbl[6] = '{pos: 79,  d: 8'hAD, k: 1'b0};
    ilas_tbl[7] = '{pos: 200, d: 8'hC8, k: 1'b0};
    ilas_tbl[8] = '{pos: 255, d: 8'h7C, k: 1'b1};

    for (int i = 0; i < 256; i++) begin
      data_tbl.push_back('{d: 8'(i), v: 1'b1, ed: 8'(i), ev: 1'b1});
      if (i % 50 == 49) data_tbl.push_back('{d: 8'h5A, v: 1'b0, ed: 8'h00, ev: 1'b0});
    end

    // Reset state.
    rst_n = 1'b0; i_sync_n = 1'b0; i_data = 8'h00; i_vld = 1'b0;
    cap_en = 1'b0; cap_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // SYNC~ held low: comma stream.
    for (int i = 0; i < 200; i++) step();

    // Release SYNC~ mid-multiframe at lmfc count 10.
    for (int i = 0; i < FK && (m_cyc % FK) != 10; i++) step();
    check("release_phase", 32'(m_cyc % FK), 32'd10);
    i_sync_n = 1'b1;
    cap_en = 1'b1; cap_n = 0;
    for (int i = 0; i < 600 && m_mode != 2; i++) step();
    check("reach_data", 32'(m_mode), 32'd2);
    cap_en = 1'b0;
    check("ilas_len", 32'(cap_n), 32'd256);
    foreach (ilas_tbl[j])
      check($sformatf("ilas_oct%0d", ilas_tbl[j].pos), 32'(cap[ilas_tbl[j].pos]),
            32'({ilas_tbl[j].k, ilas_tbl[j].d}));

    // DATA pass-through table.
    foreach (data_tbl[j]) begin
      i_data = data_tbl[j].d; i_vld = data_tbl[j].v;
      step();
      check("tbl_vld", 32'(o_vld), 32'(data_tbl[j].ev));
      if (data_tbl[j].ev) begin
        check("tbl_data", 32'(o_data), 32'(data_tbl[j].ed));
        check("tbl_k", 32'(o_k), 32'h0);
      end
    end

    // Short SYNC~ pulse is ignored.
    i_sync_n = 1'b0;
    repeat (4) begin i_data = 8'($urandom); i_vld = 1'b1; step(); end
    i_sync_n = 1'b1;
    repeat (3) begin i_data = 8'($urandom); step(); end
    check("pulse4_state", 32'(o_state), 32'd2);
    check("pulse4_ready", 32'(o_ready), 32'd1);

    // Sustained SYNC~ low forces CGS.
    i_sync_n = 1'b0;
    repeat (6) begin i_data = 8'($urandom); step(); end
    check("loss5_state", 32'(o_state), 32'd0);
    check("loss5_data", 32'(o_data), 32'hBC);
    check("loss5_k", 32'(o_k), 32'd1);

    // Randomised SYNC~ runs and data, checked against the model.
    for (int seg = 0; seg < 60; seg++) begin
      bit lvl;
      int len;
      lvl = ($urandom_range(0, 3) != 0);
      len = lvl ? int'($urandom_range(1, 150)) : int'($urandom_range(1, 8));
      for (int c = 0; c < len; c++) begin
        i_sync_n = lvl;
        i_data   = 8'($urandom);
        i_vld    = 1'($urandom);
        step();
      end
    end

    // Reset asserted at ILAS index 100.
    i_sync_n = 1'b0;
    repeat (N + 1) step();
    i_sync_n = 1'b1;
    for (int i = 0; i < 400 && !(m_mode == 1 && m_ilas == 100); i++) step();
    check("reach_ilas100", 32'(m_ilas), 32'd100);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("abort_hold");
    rst_n = 1'b1;
    step();
    check("post_reset_data", 32'(o_data), 32'hBC);
    check("post_reset_k", 32'(o_k), 32'd1);
    cap_en = 1'b1; cap_n = 0;
    for (int i = 0; i < 600 && m_mode != 2; i++) step();
    cap_en = 1'b0;
    check("restart_data", 32'(m_mode), 32'd2);
    check("restart_len", 32'(cap_n), 32'd256);
    check("restart_first", 32'(cap[0]), 32'({1'b1, 8'h1C}));
    check("restart_ramp", 32'(cap[100]), 32'({1'b0, 8'd100}));
    repeat (10) begin i_data = 8'($urandom); i_vld = 1'($urandom); step(); end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
